// File: rtl/adder_word_sequencer.sv
// adder_word_sequencer
//
// Multi-precision adder/subtractor. It reuses one 4-bit nibble add slice
// over NIBBLES cycles and ripples the carry from the LSB nibble to the MSB
// nibble. Subtraction is done as A + ~B + 1.
//
// Operands are accepted on a valid/ready handshake. Results are presented
// on a second valid/ready handshake and held under backpressure.
//
// Parameters:
//   NIBBLES      operand width in nibbles (W = 4*NIBBLES), 1..16
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   in_valid     operand request valid
//   in_ready     block can accept operands (IDLE)
//   in_a, in_b   operands, W bits
//   in_sub       1 = A-B, 0 = A+B
//   out_valid    result valid (DONE)
//   out_ready    consumer accepts result
//   out_sum      W-bit result, held until the next completion
//   out_carry    carry out of the MSB nibble (subtract: 1 = no borrow)
//   out_overflow two's-complement signed overflow
//   busy         high in RUN or DONE
//
// Optional build macro:
//   ADDSEQ_SATURATE_EN  clamps out_sum to the most positive or most
//                       negative value on signed overflow. out_carry and
//                       out_overflow still report the unclamped result.

module adder_word_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_carry,
  output logic                 out_overflow,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  // The latched operands shift right one nibble per RUN cycle. Because of
  // that, the nibble being added is always in bits [3:0].
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  acc_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;

  logic [W-1:0]  sum_q;
  logic          out_carry_q;
  logic          out_ovf_q;

  logic [4:0]    nib_add;
  logic [W+3:0]  acc_shift;
  logic [W+3:0]  a_shift;
  logic [W+3:0]  b_shift;
  logic [W-1:0]  acc_next;
  logic [W-1:0]  result;
  logic          last;
  logic          ovf_next;

  // Nibble slice and accumulator update. New sum nibbles enter at the top
  // of the accumulator and move down one nibble per cycle. After NIBBLES
  // cycles, the LSB nibble has reached bits [3:0].
  // On the last cycle, a_q[3] and b_q[3] are the sign bits of the latched
  // operands. That is why the overflow and saturation terms use those bits.
  always_comb begin
    nib_add   = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
    acc_shift = {nib_add[3:0], acc_q};
    acc_next  = acc_shift[W+3:4];
    a_shift   = {4'b0000, a_q};
    b_shift   = {4'b0000, b_q};
    last      = (idx_q == IW'(NIBBLES - 1));
    ovf_next  = (a_q[3] == b_q[3]) && (nib_add[3] != a_q[3]);
    result    = acc_next;
`ifdef ADDSEQ_SATURATE_EN
    if (ovf_next) begin
      result = a_q[3] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs. in_ready is low in DONE, so an
  // accept can never happen on the same edge that retires a result.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, ripple datapath and result registers. The result
  // registers load only on the edge that enters DONE. They keep their
  // values in IDLE until the next completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b ^ {W{in_sub}};
            carry_q <= in_sub;
            idx_q   <= '0;
            acc_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_shift[W+3:4];
          b_q     <= b_shift[W+3:4];
          acc_q   <= acc_next;
          carry_q <= nib_add[4];
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            sum_q       <= result;
            out_carry_q <= nib_add[4];
            out_ovf_q   <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum      = sum_q;
  assign out_carry    = out_carry_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_adder_word_sequencer.sv
// tb_adder_word_sequencer
//
// Directed testbench for adder_word_sequencer with NIBBLES=4.
// Each accepted operand pair pushes its expected result, computed by a
// 17-bit arithmetic model, into a queue. The entry is popped and compared
// when the DUT presents out_valid.

module tb_adder_word_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_overflow;
  logic         busy;

  int   vectors;
  int   miscompares;
  res_t exp_q[$];

  adder_word_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_sub       (in_sub),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  // Free-running clock with a 10-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain wide addition of A + (B ^ sub) + sub
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub);
    res_t         r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb      = b ^ {W{sub}};
    full    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    r.sum   = full[W-1:0];
    r.carry = full[W];
    r.ovf   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
`ifdef ADDSEQ_SATURATE_EN
    if (r.ovf) r.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one operand pair while in IDLE and pushes the model result.
  // This task is entered and left at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub);
    checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(model(a, b, sub));
  endtask

  // Counts edges after the accepting edge until out_valid rises. The wait
  // is bounded.
  task automatic waitResult(input string tag);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkOutput({tag, "_latency"}, cnt, NIBBLES);
  endtask

  // Compares the presented result against the scoreboard, then retires it
  task automatic retire(input string tag);
    res_t e;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    checkOutput({tag, "_sum"},   {16'd0, out_sum},      {16'd0, e.sum});
    checkOutput({tag, "_carry"}, {31'd0, out_carry},    {31'd0, e.carry});
    checkOutput({tag, "_ovf"},   {31'd0, out_overflow}, {31'd0, e.ovf});
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_idle_after"},  {31'd0, in_ready},  32'd1);
    checkOutput({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_held_sum"},    {16'd0, out_sum},   {16'd0, e.sum});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_sub      = 1'b0;
    out_ready   = 1'b1;

    // Reset and idle state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready",  {31'd0, in_ready},     32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid},    32'd0);
    checkOutput("rst_busy",      {31'd0, busy},         32'd0);
    checkOutput("rst_sum",       {16'd0, out_sum},      32'd0);
    checkOutput("rst_carry",     {31'd0, out_carry},    32'd0);
    checkOutput("rst_ovf",       {31'd0, out_overflow}, 32'd0);

    // Basic adds, full ripple, signed overflow and subtraction
    applyStimulus(16'h0001, 16'h0001, 1'b0);
    checkOutput("run_busy", {31'd0, busy}, 32'd1);
    waitResult("add_1_1");      retire("add_1_1");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    waitResult("add_ripple");   retire("add_ripple");
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    waitResult("add_posovf");   retire("add_posovf");
    applyStimulus(16'h0003, 16'h0005, 1'b1);
    waitResult("sub_3_5");      retire("sub_3_5");
    applyStimulus(16'h8000, 16'h0001, 1'b1);
    waitResult("sub_negovf");   retire("sub_negovf");
    applyStimulus(16'hA5C3, 16'h5A3D, 1'b0);
    waitResult("add_mixed");    retire("add_mixed");

    // Backpressure: the result is held while new requests are ignored
    out_ready = 1'b0;
    applyStimulus(16'h1234, 16'h0F0F, 1'b0);
    waitResult("bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      in_sub   = 1'($urandom);
      @(posedge clk); #1;
      checkOutput("bp_in_ready",  {31'd0, in_ready},  32'd0);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_sum_stable", {16'd0, out_sum},  {16'd0, exp_q[0].sum});
    end
    in_valid = 1'b0;
    retire("bp");

    // Reset asserted on the second RUN edge discards the operation
    applyStimulus(16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    checkOutput("midrst_in_ready",  {31'd0, in_ready},     32'd1);
    checkOutput("midrst_out_valid", {31'd0, out_valid},    32'd0);
    checkOutput("midrst_busy",      {31'd0, busy},         32'd0);
    checkOutput("midrst_sum",       {16'd0, out_sum},      32'd0);
    checkOutput("midrst_carry",     {31'd0, out_carry},    32'd0);
    checkOutput("midrst_ovf",       {31'd0, out_overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(16'h1234, 16'h1111, 1'b0);
    waitResult("after_rst");
    checkOutput("after_rst_const", {16'd0, out_sum}, 32'h2345);
    retire("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
